// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RxD deserialised into 5..8-bit characters with parity/framing flags.
// Strobe lands one cycle after the stop-bit mid-point sample; there is no back-pressure, so a missed strobe loses the character.
module uart_rx (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        RxD_i,
   input  logic [15:0] Freq_Divide_Param_i,
   input  logic [1:0]  Rx_BitLength_i,
   input  logic        Rx_ParityEN_i,
   input  logic        Rx_OddParity_i,
   input  logic        Rx_Enable_i,
   output logic [7:0]  Rx_Data_o,
   output logic        Rx_Valid_o,
   output logic        Rx_ParityErr_o,
   output logic        Rx_FrameErr_o,
   output logic        Rx_Busy_o
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t      state, state_next;
   logic        rx_meta, rxs, rxs_d;
   logic [15:0] cnt;
   logic [15:0] n_lat;
   logic [1:0]  len_lat;
   logic        par_en_lat, odd_lat;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        par_err_lat;
   logic        smp;
   logic        start_edge;
   logic [15:0] half_m1, full_m1;

   assign start_edge = rxs_d & ~rxs;
   assign half_m1    = (n_lat >> 1) - 16'd1;
   assign full_m1    = n_lat - 16'd1;

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= RxD_i;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   always_comb begin
      state_next = state;
      smp        = 1'b0;
      case (state)
         IDLE: begin
            if (Rx_Enable_i && start_edge) state_next = START;
         end
         START: begin
            if (cnt == half_m1) begin
               smp        = 1'b1;
               state_next = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == full_m1) begin
               smp = 1'b1;
               // last data bit index is L-1 = 4 + length code
               if (bit_idx == {1'b1, len_lat}) state_next = par_en_lat ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (cnt == full_m1) begin
               smp        = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == full_m1) begin
               smp        = 1'b1;
               state_next = rxs ? IDLE : BREAK;
            end
         end
         BREAK: begin
            if (rxs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (state != IDLE && !Rx_Enable_i) begin
         state_next = IDLE;
         smp        = 1'b0;
      end
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         state     <= IDLE;
         Rx_Busy_o <= 1'b0;
      end else begin
         state     <= state_next;
         Rx_Busy_o <= (state_next != IDLE);
      end
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         cnt <= 16'd0;
      end else if (state_next != state || smp || state == IDLE || state == BREAK) begin
         cnt <= 16'd0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   always_ff @(posedge m_clock or negedge p_reset) begin
      if (!p_reset) begin
         n_lat          <= 16'd4;
         len_lat        <= 2'b00;
         par_en_lat     <= 1'b0;
         odd_lat        <= 1'b0;
         bit_idx        <= 3'd0;
         shreg          <= 8'h00;
         par_err_lat    <= 1'b0;
         Rx_Data_o      <= 8'h00;
         Rx_Valid_o     <= 1'b0;
         Rx_ParityErr_o <= 1'b0;
         Rx_FrameErr_o  <= 1'b0;
      end else begin
         Rx_Valid_o <= 1'b0;
         if (state == IDLE && state_next == START) begin
            n_lat       <= (Freq_Divide_Param_i < 16'd4) ? 16'd4 : Freq_Divide_Param_i;
            len_lat     <= Rx_BitLength_i;
            par_en_lat  <= Rx_ParityEN_i;
            odd_lat     <= Rx_OddParity_i;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            par_err_lat <= 1'b0;
         end
         if (smp && state == DATA) begin
            shreg[bit_idx] <= rxs;
            if (bit_idx != {1'b1, len_lat}) bit_idx <= bit_idx + 3'd1;
         end
         if (smp && state == PARITY) par_err_lat <= (^shreg) ^ rxs ^ odd_lat;
         if (smp && state == STOP) begin
            Rx_Valid_o     <= 1'b1;
            Rx_Data_o      <= shreg;
            Rx_ParityErr_o <= par_err_lat;
            Rx_FrameErr_o  <= ~rxs;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, random frames against a timing/parity model, and abort corner cases.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst_n, rxd, par_en, odd, en;
   logic [15:0] div;
   logic [1:0]  blen;
   logic [7:0]  data;
   logic        valid, perr, ferr, busy;

   int cyc        = 0;
   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx dut (
      .m_clock(clk), .p_reset(rst_n), .RxD_i(rxd),
      .Freq_Divide_Param_i(div), .Rx_BitLength_i(blen),
      .Rx_ParityEN_i(par_en), .Rx_OddParity_i(odd), .Rx_Enable_i(en),
      .Rx_Data_o(data), .Rx_Valid_o(valid), .Rx_ParityErr_o(perr),
      .Rx_FrameErr_o(ferr), .Rx_Busy_o(busy)
   );

   typedef struct { int cyc; logic [7:0] d; logic pe; logic fe; } strobe_t;
   strobe_t sq[$];

   always @(negedge clk) if (valid) sq.push_back('{cyc, data, perr, ferr});

   typedef struct {
      logic [7:0] d; logic [1:0] blen; logic pe; logic odd; logic pbit; logic stop; int n;
      logic [7:0] ed; logic epe; logic efe;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // all stimulus tasks start and end 1 time unit after a rising edge
   task automatic drive_bit(input logic v, input int n);
      rxd = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input int l, input logic pe, input logic pbit,
                             input logic stop, input int n, output int fall);
      fall = cyc;
      drive_bit(1'b0, n);
      for (int i = 0; i < l; i++) drive_bit(d[i], n);
      if (pe) drive_bit(pbit, n);
      drive_bit(stop, n);
   endtask

   function automatic int eff_n(input int n);
      return (n < 4) ? 4 : n;
   endfunction

   // strobe cycle: 2 sync flops + edge flop, half a bit to the start mid-point, then one bit per field
   function automatic int exp_cycle(input int fall, input int n, input int l, input logic pe);
      int nn;
      nn = eff_n(n);
      return fall + 3 + nn / 2 + (l + int'(pe) + 1) * nn;
   endfunction

   function automatic logic exp_perr(input logic [7:0] dm, input logic pe, input logic o, input logic pbit);
      if (!pe) return 1'b0;
      return ((($countones(dm) + int'(pbit)) % 2) != int'(o));
   endfunction

   task automatic wait_strobe(input string name, input int bound);
      int i;
      i = 0;
      while (sq.size() == 0 && i < bound) begin
         @(posedge clk);
         #1;
         i++;
      end
      check({name, "_strobe_seen"}, 32'(sq.size() != 0), 32'd1);
   endtask

   task automatic check_frame(input string name, input logic [7:0] ed, input logic epe,
                              input logic efe, input int ecyc);
      strobe_t s;
      wait_strobe(name, 2000);
      if (sq.size() != 0) begin
         s = sq.pop_front();
         check({name, "_data"}, 32'(s.d), 32'(ed));
         check({name, "_perr"}, 32'(s.pe), 32'(epe));
         check({name, "_ferr"}, 32'(s.fe), 32'(efe));
         check({name, "_cycle"}, 32'(s.cyc), 32'(ecyc));
      end
   endtask

   task automatic set_cfg(input int n, input logic [1:0] b, input logic p, input logic o);
      div = 16'(n); blen = b; par_en = p; odd = o;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t       vt[8];
      int         fall, fall2, l, n;
      logic [7:0] d, mask;
      logic       p, o, pb, st;
      strobe_t    s1, s2;
      logic       seen;

      vt[0] = '{8'h38, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 32, 8'h38, 1'b0, 1'b0};
      vt[1] = '{8'h55, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 32, 8'h55, 1'b0, 1'b0};
      vt[2] = '{8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 32, 8'h55, 1'b1, 1'b0};
      vt[3] = '{8'h55, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 32, 8'h55, 1'b1, 1'b0};
      vt[4] = '{8'h55, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 32, 8'h55, 1'b0, 1'b0};
      vt[5] = '{8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1,  8, 8'h1F, 1'b0, 1'b0};
      vt[6] = '{8'hC3, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1,  2, 8'h03, 1'b0, 1'b0};
      vt[7] = '{8'h2A, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 12, 8'h2A, 1'b0, 1'b1};

      rst_n = 1'b0; rxd = 1'b1; en = 1'b1;
      set_cfg(32, 2'b11, 1'b0, 1'b0);
      #23;
      check("reset_data",  32'(data),  32'h0);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_perr",  32'(perr),  32'h0);
      check("reset_ferr",  32'(ferr),  32'h0);
      check("reset_busy",  32'(busy),  32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_bit(1'b1, 10);

      for (int i = 0; i < 8; i++) begin
         set_cfg(vt[i].n, vt[i].blen, vt[i].pe, vt[i].odd);
         send_frame(vt[i].d, int'(vt[i].blen) + 5, vt[i].pe, vt[i].pbit, vt[i].stop, eff_n(vt[i].n), fall);
         drive_bit(1'b1, 3 * eff_n(vt[i].n));
         check_frame($sformatf("vec%0d", i), vt[i].ed, vt[i].epe, vt[i].efe,
                     exp_cycle(fall, vt[i].n, int'(vt[i].blen) + 5, vt[i].pe));
      end

      for (int r = 0; r < 12; r++) begin
         n  = $urandom_range(1, 40);
         l  = $urandom_range(5, 8);
         p  = 1'($urandom_range(0, 1));
         o  = 1'($urandom_range(0, 1));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 7) != 0);
         d  = 8'($urandom_range(0, 255));
         mask = 8'hFF >> (8 - l);
         set_cfg(n, 2'(l - 5), p, o);
         send_frame(d, l, p, pb, st, eff_n(n), fall);
         drive_bit(1'b1, 2 * eff_n(n));
         check_frame($sformatf("rand%0d", r), d & mask, exp_perr(d & mask, p, o, pb), ~st,
                     exp_cycle(fall, n, l, p));
      end

      // framing error followed by a held-low break
      set_cfg(16, 2'b00, 1'b0, 1'b0);
      send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0, 16, fall);
      drive_bit(1'b0, 100);
      check_frame("break", 8'h1F, 1'b0, 1'b1, exp_cycle(fall, 16, 5, 1'b0));
      check("break_no_extra", 32'(sq.size()), 32'd0);
      check("break_busy", 32'(busy), 32'd1);
      drive_bit(1'b1, 40);
      check("break_release_none", 32'(sq.size()), 32'd0);
      check("break_release_idle", 32'(busy), 32'd0);
      send_frame(8'h0B, 5, 1'b0, 1'b0, 1'b1, 16, fall);
      drive_bit(1'b1, 40);
      check_frame("after_break", 8'h0B, 1'b0, 1'b0, exp_cycle(fall, 16, 5, 1'b0));

      // glitch rejection
      set_cfg(32, 2'b11, 1'b0, 1'b0);
      drive_bit(1'b0, 3);
      seen = 1'b0;
      rxd  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("glitch_busy_seen", 32'(seen), 32'd1);
      check("glitch_busy_clear", 32'(busy), 32'd0);
      drive_bit(1'b1, 40);
      check("glitch_no_strobe", 32'(sq.size()), 32'd0);

      // back-to-back frames, no idle gap
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 32, fall);
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 32, fall2);
      drive_bit(1'b1, 64);
      wait_strobe("b2b_first", 100);
      if (sq.size() >= 2) begin
         s1 = sq.pop_front();
         s2 = sq.pop_front();
         check("b2b_data0", 32'(s1.d), 32'hA5);
         check("b2b_data1", 32'(s2.d), 32'h3C);
         check("b2b_spacing", 32'(s2.cyc - s1.cyc), 32'd320);
         check("b2b_cycle0", 32'(s1.cyc - fall), 32'd307);
      end else begin
         check("b2b_two_strobes", 32'(sq.size()), 32'd2);
      end

      // receiver disabled mid-DATA
      fork
         send_frame(8'h38, 8, 1'b0, 1'b0, 1'b1, 32, fall);
         begin
            repeat (100) @(posedge clk);
            #2 en = 1'b0;
            repeat (2) @(posedge clk);
            #1 check("abort_en_idle", 32'(busy), 32'd0);
         end
      join
      en = 1'b1;
      drive_bit(1'b1, 40);
      check("abort_en_no_strobe", 32'(sq.size()), 32'd0);
      check("abort_en_hold", 32'(data), 32'h3C);
      send_frame(8'h38, 8, 1'b0, 1'b0, 1'b1, 32, fall);
      drive_bit(1'b1, 40);
      check_frame("after_en_abort", 8'h38, 1'b0, 1'b0, exp_cycle(fall, 32, 8, 1'b0));

      // asynchronous reset mid-frame
      fork
         send_frame(8'hC6, 8, 1'b0, 1'b0, 1'b1, 32, fall);
         begin
            repeat (100) @(posedge clk);
            #3 rst_n = 1'b0;
            en = 1'b0;
            #1;
            check("rst_mid_data",  32'(data),  32'h0);
            check("rst_mid_valid", 32'(valid), 32'h0);
            check("rst_mid_perr",  32'(perr),  32'h0);
            check("rst_mid_ferr",  32'(ferr),  32'h0);
            check("rst_mid_busy",  32'(busy),  32'h0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      en = 1'b1;
      drive_bit(1'b1, 40);
      check("rst_mid_no_strobe", 32'(sq.size()), 32'd0);
      send_frame(8'h38, 8, 1'b0, 1'b0, 1'b1, 32, fall);
      drive_bit(1'b1, 40);
      check_frame("after_rst", 8'h38, 1'b0, 1'b0, exp_cycle(fall, 32, 8, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine, the receive-direction counterpart of the `uart` transmitter instantiated by `uart_top`. It deserialises an asynchronous RxD line into 5–8-bit characters. It has the same runtime-programmable divide, bit-length and parity controls as the transmitter, so one set of configuration values drives both directions. Each received character is presented with a one-cycle valid strobe and parity/framing error flags.

## Interface
- No parameters; all configuration is through runtime ports.
- `m_clock`  in  1  system clock.
- `p_reset`  in  1  asynchronous, active-low reset.
- `RxD_i`  in  1  serial input, idle high, asynchronous to `m_clock`.
- `Freq_Divide_Param_i`  in  16  bit period N in `m_clock` cycles; values below 4 are treated as 4.
- `Rx_BitLength_i`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `Rx_ParityEN_i`  in  1  1 = a parity bit follows the data bits.
- `Rx_OddParity_i`  in  1  1 = odd parity, 0 = even parity.
- `Rx_Enable_i`  in  1  receiver enable.
- `Rx_Data_o`  out  8  last received character, right-justified, unused upper bits 0.
- `Rx_Valid_o`  out  1  one-cycle strobe: a character has completed.
- `Rx_ParityErr_o`  out  1  parity error for the current `Rx_Data_o`.
- `Rx_FrameErr_o`  out  1  stop bit sampled low for the current `Rx_Data_o`.
- `Rx_Busy_o`  out  1  high in every state except IDLE.

## Operation
- **Synchroniser.** `RxD_i` passes through a 2-flop synchroniser, giving `rxs`. A third flop `rxs_d` is used for edge detection. All three reset to 1.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **Sample counter.** A 16-bit counter `cnt` is cleared on entry to each state and after each sample.
- **IDLE.** If `Rx_Enable_i`=1 and `rxs_d`=1 and `rxs`=0, go to START on the next edge. On that transition, latch N, bit length L, parity enable P and parity mode. Configuration changes mid-frame have no effect.
- **START.** Sample `rxs` when `cnt` = (N>>1)−1.
  - Sample 0: go to DATA.
  - Sample 1: false start; go to IDLE with no strobe.
- **DATA.** Sample when `cnt` = N−1. Shift LSB-first into bit position (index) of the shift register. After L samples, go to PARITY if P=1, otherwise STOP.
- **PARITY.** Sample when `cnt` = N−1. Error when the XOR of the data bits and the parity bit ≠ the odd-parity flag (even parity requires the XOR to be 0; odd parity requires it to be 1).
- **STOP.** Sample when `cnt` = N−1 (the stop-bit mid-point). In the next cycle:
  - `Rx_Valid_o`=1.
  - `Rx_Data_o`, `Rx_ParityErr_o` and `Rx_FrameErr_o` update together.
  - Next state: IDLE if the stop sample was 1, BREAK if it was 0.
- **BREAK.** Wait until `rxs`=1, then go to IDLE. No new frame is accepted while the line is held low.
- **Disable.** `Rx_Enable_i`=0 in any non-IDLE state returns the FSM to IDLE on the next edge. The partial character is discarded with no strobe, and the outputs hold their previous values.
- **Output hold.** `Rx_Data_o` and both error flags hold until the next strobe. There is no back-pressure: a consumer that misses a strobe loses that character.
- **Counter arithmetic.** All `cnt` comparisons are unsigned 16-bit; N = 65535 is legal. The bit counter is 3 bits and never wraps, because L ≤ 8.

## Timing
- **Reset values:**
  - `Rx_Data_o` = 0x00.
  - `Rx_Valid_o`, `Rx_ParityErr_o`, `Rx_FrameErr_o`, `Rx_Busy_o` = 0.
  - State = IDLE; `cnt` = 0.
- **Reset mid-frame:** asynchronous return to the reset values, with no strobe.
- **Edge to START:** if `RxD_i` falls before edge k, START is entered at edge k+2.
- **START entry to strobe:** the first sample is (N>>1) cycles after START entry; each later sample is N cycles after the previous one. With S = START entry edge, `Rx_Valid_o` is high during the cycle after edge S + (N>>1) + (L+P+1)·N.
- **Back-to-back frames:** the earliest next-start detection is the cycle the strobe is high. This is half a bit before the transmitter's stop bit ends, so frames with a full stop bit are always captured.
- **`Rx_Busy_o`** is registered from the state and is high from edge S until the IDLE return.

## Test plan
- **8N1 nominal:** N=32, 8N1, line carries 0x38 (LSB first) with 1 stop bit. Required: one `Rx_Valid_o` pulse 307 cycles after the `RxD_i` fall, `Rx_Data_o`=0x38, both error flags 0.
- **Parity:** N=32, 7E1, data 0x55 with parity bit 0 → `Rx_ParityErr_o`=0, `Rx_Data_o`=0x55. Same frame with parity bit 1 → `Rx_ParityErr_o`=1. Repeat with odd parity selected and confirm the inverse results.
- **Framing error and break:** N=16, 5-bit, data 0x1F, stop bit 0, line then held low for 100 cycles. Required: strobe with `Rx_FrameErr_o`=1 and `Rx_Data_o`=0x1F; no further strobe until the line returns high and a fresh start bit arrives.
- **Glitch rejection:** N=32, 3-cycle low pulse on an idle line → no strobe, `Rx_Busy_o` returns to 0 within 20 cycles.
- **Back-to-back frames:** N=32, 8N1, 0xA5 then 0x3C with no idle gap → two strobes exactly 320 cycles apart with the correct data.
- **Abort:** `Rx_Enable_i` deasserted during DATA, or `p_reset` pulsed mid-frame → no strobe, FSM in IDLE. Reset additionally clears all outputs. A following 0x38 frame is received correctly.
